// File: rtl/io_port_arbiter_pkg.sv
// Shared definitions for the I/O port-B arbiter: FSM state encoding,
// requester indices and a one-hot helper.
package io_port_arbiter_pkg;

    // Transaction phases: arbitrate, drive port B, collect read data.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Requester indices into the two-bit valid/grant vectors.
    localparam logic REQ_KBD = 1'b0;   // PS2 keyboard writer
    localparam logic REQ_VGA = 1'b1;   // VGA text reader

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic for the I/O port-B arbiter.
// Optional feature: IO_ARB_BURST_EN lets the previous owner keep the port
// while its burst allowance (i_burst_open) is still available.
module rr_arbiter2
    import io_port_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,        // request lines, index = requester
    input  logic       i_last_grant,   // requester granted most recently
    input  logic       i_burst_open,   // previous owner is below its burst limit
    output logic [1:0] o_grant         // one-hot grant, zero when nobody asks
);

    logic w_pick;

`ifdef IO_ARB_BURST_EN
    logic w_hold;
    assign w_hold = i_burst_open & i_valid[i_last_grant];
`else
    logic w_unused_burst;
    assign w_unused_burst = i_burst_open;
`endif

    // Pick the sole requester, or on contention the one that did not go last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        o_grant = 2'b00;
        w_pick  = ~i_last_grant;
        if (i_valid[REQ_KBD] & i_valid[REQ_VGA]) begin
`ifdef IO_ARB_BURST_EN
            if (w_hold) begin
                w_pick = i_last_grant;
            end
`endif
            o_grant = onehot2(w_pick);
        end else if (i_valid[REQ_KBD]) begin
            o_grant = onehot2(REQ_KBD);
        end else if (i_valid[REQ_VGA]) begin
            o_grant = onehot2(REQ_VGA);
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares data-memory port B between the PS2 keyboard writer (req0) and the
// VGA text reader (req1). One transaction in flight: accept, drive port B for
// one cycle, capture the synchronous read data, pulse the owner's response.
// Optional feature: IO_ARB_BURST_EN (burst grants up to MAX_BURST).
module io_port_arbiter
    import io_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_wren,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_wren,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic                  io_wren,
    output logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] io_rdata
);

    localparam int              CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wren;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_rdata;
    logic [DATA_WIDTH-1:0] r_rsp1_rdata;

    logic [1:0]            w_grant;
    logic                  w_grant_idx;
    logic                  w_burst_open;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_capture;

    // A burst is open only after at least one grant and below the limit.
    assign w_burst_open = (r_burst_cnt != '0) && (r_burst_cnt < BURST_LIMIT);
    assign w_grant_idx  = w_grant[REQ_VGA];

    rr_arbiter2 u_rr_arbiter2 (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_burst_open (w_burst_open),
        .o_grant      (w_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and phase strobes; accepting is blocked while reset is held.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && (w_grant != 2'b00)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_capture    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, grant history and burst counter, updated on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_wren       <= 1'b0;
            r_wdata      <= '0;
            r_owner      <= REQ_KBD;
            r_last_grant <= REQ_VGA;
            r_burst_cnt  <= '0;
        end else if (w_accept) begin
            r_addr       <= w_grant_idx ? req1_addr  : req0_addr;
            r_wren       <= w_grant_idx ? req1_wren  : req0_wren;
            r_wdata      <= w_grant_idx ? req1_wdata : req0_wdata;
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            if ((w_grant_idx == r_last_grant) && (r_burst_cnt != '0)) begin
                if (r_burst_cnt < BURST_LIMIT) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else begin
                r_burst_cnt <= CNT_W'(1);
            end
        end
    end

    // Response pulse and read-data capture for the latched owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid  <= 2'b00;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (w_capture) begin
                r_rsp_valid <= onehot2(r_owner);
                if (!r_wren) begin
                    if (r_owner == REQ_VGA) begin
                        r_rsp1_rdata <= io_rdata;
                    end else begin
                        r_rsp0_rdata <= io_rdata;
                    end
                end
            end
        end
    end

    assign req0_ready = w_accept & w_grant[REQ_KBD];
    assign req1_ready = w_accept & w_grant[REQ_VGA];
    assign rsp0_valid = r_rsp_valid[REQ_KBD];
    assign rsp1_valid = r_rsp_valid[REQ_VGA];
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;
    assign io_addr    = r_addr;
    assign io_wdata   = r_wdata;
    assign io_wren    = w_issue & r_wren;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: reset values, a table of single-requester
// transactions, contention ordering, reset during ISSUE, randomized traffic
// against a timeline reference model, and a long idle stretch.
// Honours IO_ARB_BURST_EN when the design is built with it.
module tb_io_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req0_wren;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_wren;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] io_addr;
    logic          io_wren;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;

    int checks = 0;
    int errors = 0;

    bit [7:0] tb_mem [0:65535];

    typedef struct {
        bit            n;
        bit            wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } txn_t;

    io_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_wren  (req0_wren),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_wren  (req1_wren),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .io_addr    (io_addr),
        .io_wren    (io_wren),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Port-B memory: write on wren, registered read of the addressed word.
    always @(posedge clk) begin
        if (io_wren) tb_mem[io_addr] <= io_wdata;
        io_rdata <= tb_mem[io_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit n, input bit v, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n) begin
            req1_valid = v; req1_wren = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_wren = w; req0_addr = a; req0_wdata = d;
        end
    endtask

    task automatic idle_inputs();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    function automatic logic [1:0] oh(input bit n);
        return n ? 2'b10 : 2'b01;
    endfunction

    // One transaction from a lone requester with cycle-exact checks.
    task automatic run_txn(input txn_t t);
        int waited;
        waited = 0;
        set_req(t.n, 1'b1, t.wren, t.addr, t.wdata);
        #1;
        while (!(t.n ? req1_ready : req0_ready) && waited < 5) begin
            tick();
            #1;
            waited++;
        end
        check("txn_ready", {req1_ready, req0_ready}, oh(t.n));
        tick();
        set_req(t.n, 1'b0, 1'b0, '0, '0);
        check("txn_issue_wren", io_wren, t.wren);
        check("txn_issue_addr", io_addr, t.addr);
        if (t.wren) check("txn_issue_wdata", io_wdata, t.wdata);
        check("txn_issue_rsp_quiet", {rsp1_valid, rsp0_valid}, 2'b00);
        tick();
        check("txn_wait_wren", io_wren, 1'b0);
        check("txn_wait_rsp_quiet", {rsp1_valid, rsp0_valid}, 2'b00);
        tick();
        check("txn_rsp_owner", {rsp1_valid, rsp0_valid}, oh(t.n));
        if (!t.wren) check("txn_rsp_rdata", t.n ? rsp1_rdata : rsp0_rdata, t.exp_rdata);
    endtask

    // Reference arbitration rules for the random phase.
    bit mlast;
    int mrun;

    function automatic bit model_pick(input bit v0, input bit v1);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
`ifdef IO_ARB_BURST_EN
        if (mrun > 0 && mrun < MB) return mlast;
`endif
        return !mlast;
    endfunction

    function automatic bit exp_order(input int k);
`ifdef IO_ARB_BURST_EN
        return ((k / MB) % 2) == 1;
`else
        return (k % 2) == 1;
`endif
    endfunction

    txn_t tbl [7];

    bit            v [2];
    bit            w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit [7:0]      mem_model [0:7];
    int            acc_cyc;
    bit            acc_n, acc_w;
    logic [AW-1:0] acc_a;
    logic [DW-1:0] acc_d, acc_exp;

    initial begin
        bit   g;
        bit   idle;
        int   waited;
        logic [1:0] exp_ready;

        tbl[0] = '{1'b0, 1'b1, 16'h0010, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'hA5};
        tbl[2] = '{1'b0, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5};
        tbl[5] = '{1'b1, 1'b1, 16'h0000, 8'h5A, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h5A};

        // Reset values, with a request pending that must not be accepted.
        idle_inputs();
        rst = 1'b0;
        req0_valid = 1'b1;
        #12;
        check("rst_io_addr", io_addr, 16'h0000);
        check("rst_io_wren", io_wren, 1'b0);
        check("rst_io_wdata", io_wdata, 8'h00);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        check("rst_rsp0_rdata", rsp0_rdata, 8'h00);
        check("rst_rsp1_rdata", rsp1_rdata, 8'h00);
        do_reset();

        // Table of lone-requester transactions, issued back to back.
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);
        tick();

        // Both requesters valid continuously: grant order and response routing.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 16'h0011, 8'h00);
        for (int k = 0; k < 8; k++) begin
            #1;
            waited = 0;
            while (!(req0_ready | req1_ready) && waited < 4) begin
                tick();
                #1;
                waited++;
            end
            g = req1_ready;
            check("both_single_ready", {1'b0, req0_ready ^ req1_ready}, 2'b01);
            check("both_grant_order", g, exp_order(k));
            tick(); tick(); tick();
            check("both_rsp_owner", {rsp1_valid, rsp0_valid}, oh(g));
            check("both_rsp_rdata", g ? rsp1_rdata : rsp0_rdata, g ? 8'h00 : 8'hA5);
        end
        idle_inputs();
        repeat (3) tick();

        // Reset during ISSUE of a req0 write; req0 must still win afterwards.
        set_req(1'b0, 1'b1, 1'b1, 16'h0040, 8'h77);
        tick();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        check("mid_issue_wren", io_wren, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wren_drop", io_wren, 1'b0);
        check("mid_rst_io_addr", io_addr, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        check("mid_rst_no_write", tb_mem[16'h0040], 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            tick();
        end
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 16'h0011, 8'h00);
        #1;
        check("post_rst_req0_first", {req1_ready, req0_ready}, 2'b01);
        tick();
        idle_inputs();
        tick(); tick();
        check("post_rst_rsp0", {rsp1_valid, rsp0_valid}, 2'b01);
        check("post_rst_rdata0", rsp0_rdata, 8'hA5);

        // Randomized traffic against the timeline model.
        do_reset();
        mlast   = 1'b1;
        mrun    = 0;
        acc_cyc = -10;
        acc_n   = 1'b0;
        acc_w   = 1'b0;
        acc_a   = '0;
        acc_d   = '0;
        acc_exp = '0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        for (int i = 0; i < 8; i++) mem_model[i] = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(0, 2) != 0) begin
                    v[n] = 1'b1;
                    w[n] = 1'($urandom_range(0, 1));
                    a[n] = 16'h0200 + 16'($urandom_range(0, 7));
                    d[n] = 8'($urandom);
                end
                set_req(n[0], v[n], w[n], a[n], d[n]);
            end
            #1;
            idle = (cyc >= acc_cyc + 3);
            exp_ready = 2'b00;
            g = 1'b0;
            if (idle && (v[0] || v[1])) begin
                g = model_pick(v[0], v[1]);
                exp_ready = oh(g);
            end
            check("rnd_ready", {req1_ready, req0_ready}, exp_ready);
            check("rnd_wren", io_wren, (cyc == acc_cyc + 1) && acc_w);
            if (cyc == acc_cyc + 1) begin
                check("rnd_addr", io_addr, acc_a);
                if (acc_w) begin
                    check("rnd_wdata", io_wdata, acc_d);
                    mem_model[acc_a[2:0]] = acc_d;
                end
            end
            check("rnd_rsp", {rsp1_valid, rsp0_valid}, (cyc == acc_cyc + 3) ? oh(acc_n) : 2'b00);
            if (cyc == acc_cyc + 3 && !acc_w)
                check("rnd_rdata", acc_n ? rsp1_rdata : rsp0_rdata, acc_exp);
            if (exp_ready != 2'b00) begin
                acc_cyc = cyc;
                acc_n   = g;
                acc_w   = w[g];
                acc_a   = a[g];
                acc_d   = d[g];
                acc_exp = mem_model[a[g][2:0]];
                if (g == mlast) mrun++;
                else mrun = 1;
                mlast   = g;
                v[g]    = 1'b0;
            end
            tick();
        end

        // Long idle: nothing moves, address holds the last command's value.
        idle_inputs();
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            check("idle_wren", io_wren, 1'b0);
            check("idle_addr", io_addr, acc_a);
            check("idle_ready", {req1_ready, req0_ready}, 2'b00);
            check("idle_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
